// File: rtl/putbits.sv
// putbits: bitstream writer. Packs MSB-first variable-length codes (0..24 bits) into
// 64-bit words for the elementary-stream output FIFO, with byte alignment and an
// end-of-stream flush that pads to a 64-bit boundary and drains the accumulator.
//
// Ports:
//   clk, clk_en, rst            clock, clock enable (all state holds when low), sync reset
//   bits_in[23:0], bits_len[4:0] right-justified code and its length (25..31 act as 24)
//   bits_valid, align, flush    request strobe and its modifiers
//   putbits_ready               request accepted when bits_valid && putbits_ready && clk_en
//   vid_out[63:0], vid_out_wr_en packed word (first stream bit at [63]) and FIFO write strobe
//   vid_out_afull               FIFO almost full; holds word emission
//   flush_done                  one-cycle pulse when a flush has fully drained
//
// Optional feature: define PUTBITS_BITCOUNT_EN to add bit_count[31:0], the number of
// bits accepted including alignment and flush padding (wraps, cleared by rst only).
module putbits #(
    parameter int unsigned ACC_W     = 128,
    parameter int unsigned READY_MAX = 96
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst,
    input  logic [23:0] bits_in,
    input  logic [4:0]  bits_len,
    input  logic        bits_valid,
    input  logic        align,
    input  logic        flush,
    output logic        putbits_ready,
    output logic [63:0] vid_out,
    output logic        vid_out_wr_en,
    input  logic        vid_out_afull,
    output logic        flush_done
`ifdef PUTBITS_BITCOUNT_EN
    ,
    output logic [31:0] bit_count
`endif
);

    typedef enum logic {StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_a, ins;
    logic [7:0]       fill_q, fill_d, fa, f1, f2, shamt;
    logic [4:0]       len;
    logic [23:0]      code;
    logic             accept, flush_act, emit, done;
    logic [63:0]      vid_out_q;
    logic             wr_en_q, flush_done_q;

    assign putbits_ready = (state_q == StRun) && (fill_q <= 8'(READY_MAX)) && !rst;
    assign vid_out       = vid_out_q;
    assign vid_out_wr_en = wr_en_q;
    assign flush_done    = flush_done_q;

    always_comb begin
        len       = (bits_len > 5'd24) ? 5'd24 : bits_len;
        code      = bits_in & ((24'd1 << len) - 24'd1);
        accept    = bits_valid && putbits_ready;
        f1        = fill_q + {3'b000, len};
        f2        = align ? {f1[7:3] + 5'(|f1[2:0]), 3'b000} : f1;
        // Code lands just below the current valid bits; bits below fill are always zero,
        // so alignment and flush padding need no explicit writes.
        shamt     = 8'(ACC_W) - f1;
        ins       = {{(ACC_W-24){1'b0}}, code} << shamt;
        acc_a     = accept ? (acc_q | ins) : acc_q;
        fa        = accept ? f2 : fill_q;
        // Flush padding is applied lazily: a partial word is emitted zero-padded.
        flush_act = (state_q == StFlush) || (accept && flush);
        emit      = !vid_out_afull && ((fa >= 8'd64) || (flush_act && (fa != 8'd0)));
        acc_d     = emit ? (acc_a << 64) : acc_a;
        fill_d    = fa;
        if (emit) begin
            fill_d = (fa >= 8'd64) ? (fa - 8'd64) : 8'd0;
        end
        done      = flush_act && (fill_d == 8'd0) && !emit;
        state_d   = (flush_act && !done) ? StFlush : StRun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            acc_q        <= '0;
            fill_q       <= '0;
            vid_out_q    <= '0;
            wr_en_q      <= 1'b0;
            flush_done_q <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            wr_en_q      <= emit;
            flush_done_q <= done;
            if (emit) begin
                vid_out_q <= acc_a[ACC_W-1 -: 64];
            end
        end
    end

`ifdef PUTBITS_BITCOUNT_EN
    logic [8:0]  f3;
    logic [31:0] bit_count_q;

    always_comb begin
        f3 = {1'b0, f2};
        if (flush) begin
            f3 = ({1'b0, f2} + 9'd63) & 9'h1C0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_count_q <= '0;
        end else if (clk_en && accept) begin
            bit_count_q <= bit_count_q + 32'(f3 - {1'b0, fill_q});
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule
